// File: rtl/saturn_pkg.sv
// Shared definitions for the Saturn control unit.
// Holds bus command codes, register ids, ALU opcodes, instruction classes,
// decoder state encoding, the decoded-field bundle and the boot program.
package saturn_pkg;

    localparam int PROG_DEPTH_DEFAULT = 32;

    // Bus command codes (low nibble of a command queue entry)
    localparam logic [3:0] BUSCMD_PC_READ = 4'd0;
    localparam logic [3:0] BUSCMD_LOAD_PC = 4'd4;

    // Register ids
    localparam logic [4:0] REG_C    = 5'd2;
    localparam logic [4:0] REG_P    = 5'd12;
    localparam logic [4:0] REG_RSTK = 5'd14;
    localparam logic [4:0] REG_NONE = 5'd31;

    // ALU opcodes
    localparam logic [4:0] OP_NONE = 5'd0;
    localparam logic [4:0] OP_COPY = 5'd1;

    typedef enum logic [3:0] {
        INSTR_NONE = 4'd0,
        INSTR_ALU  = 4'd1,
        INSTR_RTN  = 4'd2,
        INSTR_MODE = 4'd3
    } instr_type_e;

    typedef enum logic [2:0] {
        DEC_IDLE,   // waiting for the first nibble
        DEC_HAVE1,  // first nibble captured, decode pending
        DEC_WAIT2,  // waiting for the second nibble
        DEC_HAVE2,  // second nibble captured, decode pending
        DEC_ERROR   // unknown opcode seen, stuck until reset
    } dec_state_e;

    typedef struct packed {
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [3:0]  imm;
        logic [4:0]  opcode;
        instr_type_e itype;
    } decode_t;

    // Boot program: LOAD_PC command, five address nibbles of 00000, PC_READ.
    function automatic logic [4:0] boot_entry(input int idx);
        logic [4:0] e;
        case (idx)
            0:       e = {1'b1, BUSCMD_LOAD_PC};
            1, 2, 3, 4, 5: e = {1'b0, 4'h0};
            6:       e = {1'b1, BUSCMD_PC_READ};
            default: e = 5'h00;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/saturn_control_unit_decoder.sv
// saturn_inst_decoder: nibble-serial decoder for the two-nibble subset.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   freeze_i            debugger cycle: hold all state, drop the pulse
//   read_i, nibble_i    a nibble is being read this cycle
//   decode_i            decode phase strobe
//   want_nibble_o       decoder is waiting for a nibble
//   first_nibble_o      next nibble read starts a new instruction
//   error_o             sticky unknown-opcode error
//   decoded_o           one-clock completion pulse
//   fields_o            decoded register ids, immediate, opcode, class
module saturn_inst_decoder
    import saturn_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       freeze_i,
    input  logic       read_i,
    input  logic       decode_i,
    input  logic [3:0] nibble_i,
    output logic       want_nibble_o,
    output logic       first_nibble_o,
    output logic       error_o,
    output logic       decoded_o,
    output decode_t    fields_o
);

    dec_state_e state_q, state_d;
    logic [3:0] nib0_q, nib0_d, nib1_q, nib1_d;
    decode_t    fields_q, fields_d;
    logic       decoded_q, decoded_d;

    decode_t    cand;
    logic       cand_valid;

    // Field table for the full two-nibble instruction held in nib0/nib1.
    always_comb begin
        cand        = '0;
        cand.dest   = REG_NONE;
        cand.src1   = REG_NONE;
        cand.src2   = REG_NONE;
        cand.itype  = INSTR_NONE;
        cand_valid  = 1'b1;
        if (nib0_q == 4'h2) begin
            cand.itype  = INSTR_ALU;
            cand.dest   = REG_P;
            cand.imm    = nib1_q;
            cand.opcode = OP_COPY;
        end else if (nib0_q == 4'h0) begin
            case (nib1_q)
                4'h0, 4'h1, 4'h2, 4'h3: begin
                    cand.itype = INSTR_RTN;
                    cand.imm   = nib1_q;
                end
                4'h4, 4'h5: begin
                    cand.itype = INSTR_MODE;
                    cand.imm   = nib1_q;
                end
                4'h6: begin
                    cand.itype  = INSTR_ALU;
                    cand.dest   = REG_RSTK;
                    cand.src1   = REG_C;
                    cand.opcode = OP_COPY;
                end
                4'h7: begin
                    cand.itype  = INSTR_ALU;
                    cand.dest   = REG_C;
                    cand.src1   = REG_RSTK;
                    cand.opcode = OP_COPY;
                end
                default: cand_valid = 1'b0;
            endcase
        end else begin
            cand_valid = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib0_d    = nib0_q;
        nib1_d    = nib1_q;
        fields_d  = fields_q;
        decoded_d = 1'b0;
        if (!freeze_i) begin
            case (state_q)
                DEC_IDLE: if (read_i) begin
                    nib0_d  = nibble_i;
                    state_d = DEC_HAVE1;
                end
                // Only prefixes 0 and 2 continue; anything else is unknown.
                DEC_HAVE1: if (decode_i) begin
                    state_d = (nib0_q == 4'h0 || nib0_q == 4'h2) ? DEC_WAIT2 : DEC_ERROR;
                end
                DEC_WAIT2: if (read_i) begin
                    nib1_d  = nibble_i;
                    state_d = DEC_HAVE2;
                end
                DEC_HAVE2: if (decode_i) begin
                    if (cand_valid) begin
                        fields_d  = cand;
                        decoded_d = 1'b1;
                        state_d   = DEC_IDLE;
                    end else begin
                        state_d = DEC_ERROR;
                    end
                end
                default: state_d = DEC_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= DEC_IDLE;
            nib0_q    <= 4'h0;
            nib1_q    <= 4'h0;
            fields_q  <= '0;
            decoded_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib0_q    <= nib0_d;
            nib1_q    <= nib1_d;
            fields_q  <= fields_d;
            decoded_q <= decoded_d;
        end
    end

    assign want_nibble_o  = (state_q == DEC_IDLE) || (state_q == DEC_WAIT2);
    assign first_nibble_o = (state_q == DEC_IDLE);
    assign error_o        = (state_q == DEC_ERROR);
    assign decoded_o      = decoded_q;
    assign fields_o       = fields_q;

endmodule

// File: rtl/saturn_control_unit.sv
// saturn_control_unit: master sequencer of the Saturn core.
// Keeps the boot bus-program queue, the program counter and fetch gating;
// instruction decoding is delegated to saturn_inst_decoder.
// Ports:
//   i_clk, i_reset           clock, asynchronous active-low reset
//   i_phases / i_phase       one-hot and binary bus phase
//   i_cycle_ctr              cycle counter (informational)
//   i_debug_cycle            freeze request from the debugger
//   i_bus_busy               bus controller still draining the queue
//   o_program_address        queue write pointer
//   i_program_address        bus controller read pointer
//   o_program_data           queue entry at the read pointer
//   o_no_read                inhibit nibble reads
//   i_nibble                 nibble read from the bus
//   o_error                  sticky decode error
//   o_current_pc             address of the current instruction
//   o_alu_* / o_instr_type   decoded fields
//   o_instr_decoded          decode-complete pulse
module saturn_control_unit
    import saturn_pkg::*;
#(
    parameter int PROG_DEPTH = PROG_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_debug_cycle,
    input  logic        i_bus_busy,
    output logic [4:0]  o_program_address,
    input  logic [4:0]  i_program_address,
    output logic [4:0]  o_program_data,
    output logic        o_no_read,
    input  logic [3:0]  i_nibble,
    output logic        o_error,
    output logic [19:0] o_current_pc,
    output logic [4:0]  o_alu_reg_dest,
    output logic [4:0]  o_alu_reg_src_1,
    output logic [4:0]  o_alu_reg_src_2,
    output logic [3:0]  o_alu_imm_value,
    output logic [4:0]  o_alu_opcode,
    output logic [3:0]  o_instr_type,
    output logic        o_instr_decoded
);

    logic [4:0]  prog_q [PROG_DEPTH];
    logic [4:0]  wr_ptr_q;
    logic [19:0] pc_q, pc_d;
    logic [19:0] cur_pc_q, cur_pc_d;

    logic    queue_empty, read_en, decode_en;
    logic    dec_want, dec_first, dec_error, dec_decoded;
    decode_t dec_fields;

    // Phase index and cycle counter only feed simulation messages.
    logic unused_msg_inputs;
    assign unused_msg_inputs = ^{i_phase, i_cycle_ctr};

    // Boot program is loaded on reset; nothing else writes the queue.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) prog_q[i] <= boot_entry(i);
            wr_ptr_q <= 5'd7;
        end
    end

    assign o_program_data    = prog_q[i_program_address];
    assign o_program_address = wr_ptr_q;
    assign queue_empty       = (i_program_address == wr_ptr_q);
    assign o_no_read         = i_bus_busy | dec_error | !queue_empty;

    // A nibble is consumed only when the decoder can take it, so a deferred
    // decode never loses a nibble or advances the PC past it.
    assign read_en   = (i_phases == 4'b0010) && !o_no_read && !i_debug_cycle && dec_want;
    assign decode_en = (i_phases == 4'b0100);

    always_comb begin
        pc_d     = pc_q;
        cur_pc_d = cur_pc_q;
        if (read_en) begin
            pc_d = pc_q + 20'd1;
            if (dec_first) cur_pc_d = pc_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q     <= 20'd0;
            cur_pc_q <= 20'd0;
        end else begin
            pc_q     <= pc_d;
            cur_pc_q <= cur_pc_d;
        end
    end

    saturn_inst_decoder u_decoder (
        .clk_i          (i_clk),
        .rst_ni         (i_reset),
        .freeze_i       (i_debug_cycle),
        .read_i         (read_en),
        .decode_i       (decode_en),
        .nibble_i       (i_nibble),
        .want_nibble_o  (dec_want),
        .first_nibble_o (dec_first),
        .error_o        (dec_error),
        .decoded_o      (dec_decoded),
        .fields_o       (dec_fields)
    );

    assign o_error         = dec_error;
    assign o_current_pc    = cur_pc_q;
    assign o_alu_reg_dest  = dec_fields.dest;
    assign o_alu_reg_src_1 = dec_fields.src1;
    assign o_alu_reg_src_2 = dec_fields.src2;
    assign o_alu_imm_value = dec_fields.imm;
    assign o_alu_opcode    = dec_fields.opcode;
    assign o_instr_type    = dec_fields.itype;
    assign o_instr_decoded = dec_decoded;

endmodule

// File: tb/tb_saturn_control_unit.sv
module tb_saturn_control_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_phases;
    logic [1:0]  i_phase;
    logic [31:0] i_cycle_ctr;
    logic        i_debug_cycle;
    logic        i_bus_busy;
    logic [4:0]  o_program_address;
    logic [4:0]  i_program_address;
    logic [4:0]  o_program_data;
    logic        o_no_read;
    logic [3:0]  i_nibble;
    logic        o_error;
    logic [19:0] o_current_pc;
    logic [4:0]  o_alu_reg_dest, o_alu_reg_src_1, o_alu_reg_src_2, o_alu_opcode;
    logic [3:0]  o_alu_imm_value, o_instr_type;
    logic        o_instr_decoded;

    saturn_control_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_phases(i_phases), .i_phase(i_phase),
        .i_cycle_ctr(i_cycle_ctr), .i_debug_cycle(i_debug_cycle), .i_bus_busy(i_bus_busy),
        .o_program_address(o_program_address), .i_program_address(i_program_address),
        .o_program_data(o_program_data), .o_no_read(o_no_read), .i_nibble(i_nibble),
        .o_error(o_error), .o_current_pc(o_current_pc), .o_alu_reg_dest(o_alu_reg_dest),
        .o_alu_reg_src_1(o_alu_reg_src_1), .o_alu_reg_src_2(o_alu_reg_src_2),
        .o_alu_imm_value(o_alu_imm_value), .o_alu_opcode(o_alu_opcode),
        .o_instr_type(o_instr_type), .o_instr_decoded(o_instr_decoded)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: instruction-level view of the fetch stream.
    typedef struct {
        bit valid;
        int ty, dest, s1, s2, imm, op;
    } exp_t;

    int unsigned model_pc;
    int unsigned last_cur_pc;
    bit          force_dbg;

    function automatic exp_t ref_decode(input int n0, input int n1);
        exp_t e;
        e.valid = 1; e.ty = 0; e.dest = 31; e.s1 = 31; e.s2 = 31; e.imm = 0; e.op = 0;
        if (n0 == 2) begin
            e.ty = 1; e.dest = 12; e.imm = n1; e.op = 1;
        end else if (n0 == 0 && n1 <= 3) begin
            e.ty = 2; e.imm = n1;
        end else if (n0 == 0 && n1 <= 5) begin
            e.ty = 3; e.imm = n1;
        end else if (n0 == 0 && n1 == 6) begin
            e.ty = 1; e.dest = 14; e.s1 = 2; e.op = 1;
        end else if (n0 == 0 && n1 == 7) begin
            e.ty = 1; e.dest = 2; e.s1 = 14; e.op = 1;
        end else begin
            e.valid = 0;
        end
        return e;
    endfunction

    task automatic tick(input logic [3:0] ph, input logic dbg);
        i_phases      = ph;
        i_phase       = (ph == 4'b0001) ? 2'd0 : (ph == 4'b0010) ? 2'd1 : (ph == 4'b0100) ? 2'd2 : 2'd3;
        i_debug_cycle = dbg;
        @(posedge i_clk);
        #1;
        i_debug_cycle = 1'b0;
        i_cycle_ctr++;
    endtask

    // Runs bus cycles until the nibble is accepted; returns just after the 0100 edge.
    task automatic feed_nibble(input logic [3:0] nib, input bit first);
        bit dbg;
        bit done = 0;
        while (!done) begin
            dbg = force_dbg || ($urandom_range(0, 3) == 0);
            force_dbg = 0;
            i_nibble = nib;
            tick(4'b0001, 1'b0);
            tick(4'b0010, dbg);
            if (dbg) begin
                check("freeze_cur_pc", o_current_pc, last_cur_pc);
                tick(4'b0100, 1'b0);
                check("freeze_no_decode", o_instr_decoded, 0);
                check("freeze_no_error", o_error, 0);
                tick(4'b1000, 1'b0);
            end else begin
                if (first) begin
                    last_cur_pc = model_pc;
                    check("cur_pc_latch", o_current_pc, model_pc);
                end
                model_pc = (model_pc + 1) & 32'hFFFFF;
                tick(4'b0100, 1'b0);
                done = 1;
            end
        end
    endtask

    task automatic run_instr(input int n0, input int n1);
        exp_t e;
        e = ref_decode(n0, n1);
        feed_nibble(n0[3:0], 1);
        if (!(n0 == 0 || n0 == 2)) begin
            check("err_first", o_error, 1);
            check("err_first_nodec", o_instr_decoded, 0);
            check("err_first_noread", o_no_read, 1);
            tick(4'b1000, 1'b0);
            return;
        end
        check("dec_after_n0", o_instr_decoded, 0);
        tick(4'b1000, 1'b0);
        feed_nibble(n1[3:0], 0);
        if (!e.valid) begin
            check("err_second", o_error, 1);
            check("err_second_nodec", o_instr_decoded, 0);
            check("err_second_noread", o_no_read, 1);
            tick(4'b1000, 1'b0);
            return;
        end
        $display("decode %0h%0h at pc %0h", n0, n1, last_cur_pc);
        check("decoded", o_instr_decoded, 1);
        check("type", o_instr_type, e.ty);
        check("dest", o_alu_reg_dest, e.dest);
        check("src1", o_alu_reg_src_1, e.s1);
        check("src2", o_alu_reg_src_2, e.s2);
        check("imm", o_alu_imm_value, e.imm);
        check("opcode", o_alu_opcode, e.op);
        check("cur_pc", o_current_pc, last_cur_pc);
        check("no_error", o_error, 0);
        tick(4'b1000, 1'b0);
        check("pulse_len", o_instr_decoded, 0);
    endtask

    task automatic drain();
        logic [4:0] boot [7];
        boot = '{5'h14, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h10};
        i_bus_busy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_program_address = 5'(k);
            #1;
            check("queue_data", o_program_data, boot[k]);
            check("drain_no_read", o_no_read, 1);
            tick(4'b0001, 1'b0);
            tick(4'b0010, 1'b0);
            tick(4'b0100, 1'b0);
            tick(4'b1000, 1'b0);
        end
        i_program_address = 5'd7;
        #1;
        check("busy_no_read", o_no_read, 1);
        i_bus_busy = 1'b0;
        #1;
        check("ready_no_read", o_no_read, 0);
        model_pc    = 0;
        last_cur_pc = 0;
    endtask

    task automatic assert_reset(input string tag);
        i_program_address = 5'd0;
        i_bus_busy        = 1'b1;
        i_reset           = 1'b0;
        #2;
        check({tag, "_error"}, o_error, 0);
        check({tag, "_wptr"}, o_program_address, 7);
        check({tag, "_decoded"}, o_instr_decoded, 0);
        check({tag, "_cur_pc"}, o_current_pc, 0);
        check({tag, "_no_read"}, o_no_read, 1);
        tick(4'b1000, 1'b0);
        i_reset = 1'b1;
        tick(4'b1000, 1'b0);
    endtask

    task automatic error_tail();
        int unsigned pc_hold;
        pc_hold = o_current_pc;
        for (int k = 0; k < 3; k++) begin
            i_nibble = 4'h2;
            tick(4'b0001, 1'b0);
            tick(4'b0010, 1'b0);
            tick(4'b0100, 1'b0);
            check("sticky_error", o_error, 1);
            check("sticky_no_read", o_no_read, 1);
            check("sticky_nodec", o_instr_decoded, 0);
            check("sticky_cur_pc", o_current_pc, pc_hold);
            tick(4'b1000, 1'b0);
        end
        $display("decode error observed at cycle %0d", i_cycle_ctr);
    endtask

    initial begin
        int n0, n1;
        i_reset = 1'b0; i_phases = 4'b1000; i_phase = 2'd3; i_cycle_ctr = 0;
        i_debug_cycle = 1'b0; i_bus_busy = 1'b1; i_program_address = 5'd0; i_nibble = 4'h0;
        force_dbg = 0; model_pc = 0; last_cur_pc = 0;
        tick(4'b1000, 1'b0);
        tick(4'b1000, 1'b0);
        check("rst_wptr", o_program_address, 7);
        check("rst_no_read", o_no_read, 1);
        check("rst_error", o_error, 0);
        check("rst_cur_pc", o_current_pc, 0);
        check("rst_decoded", o_instr_decoded, 0);
        check("rst_type", o_instr_type, 0);
        check("rst_dest", o_alu_reg_dest, 0);
        check("rst_src1", o_alu_reg_src_1, 0);
        check("rst_src2", o_alu_reg_src_2, 0);
        check("rst_imm", o_alu_imm_value, 0);
        check("rst_opcode", o_alu_opcode, 0);
        i_reset = 1'b1;
        tick(4'b1000, 1'b0);

        drain();
        run_instr(2, 5);
        force_dbg = 1;
        run_instr(0, 3);
        force_dbg = 1;
        run_instr(0, 7);
        run_instr(0, 6);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                n0 = 2; n1 = int'($urandom_range(0, 15));
            end else begin
                n0 = 0; n1 = int'($urandom_range(0, 7));
            end
            run_instr(n0, n1);
        end

        // Unknown first nibble
        n0 = int'($urandom_range(0, 13));
        n0 = (n0 == 0) ? 1 : n0 + 2;
        run_instr(n0, 0);
        error_tail();

        // Reset clears the sticky error; unknown second nibble
        assert_reset("rst_err");
        drain();
        run_instr(0, 5);
        run_instr(0, int'($urandom_range(8, 15)));
        error_tail();

        // Reset in the middle of an instruction discards the partial nibble
        assert_reset("rst_err2");
        drain();
        run_instr(2, 9);
        i_nibble = 4'h2;
        feed_nibble(4'h2, 1);
        tick(4'b1000, 1'b0);
        check("partial_cur_pc", o_current_pc, 2);
        assert_reset("rst_mid");
        drain();
        run_instr(0, 4);
        run_instr(2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/saturn_control_unit.md
Name: saturn_control_unit

Overview:
- Master sequencer of the Saturn core.
- After reset it queues a short bus program (LOAD_PC to 00000, then PC_READ) into a 32-entry queue; the bus controller drains the queue.
- It then fetches one instruction nibble per bus cycle and decodes a small instruction subset.
- Decode results (PC, ALU fields, type) go to the debugger; an unknown opcode raises a sticky error that halts the system.

Parameters:
- PROG_DEPTH, 32, entries in the bus program queue (5-bit addresses, wraps modulo 32).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_phases  in  4  one-hot phase: 0001 = bus drive, 0010 = nibble read, 0100 = decode, 1000 = execute
- i_phase  in  2  binary phase index (for messages only)
- i_cycle_ctr  in  32  cycle counter (for messages only)
- i_debug_cycle  in  1  debugger owns this cycle; unit freezes
- i_bus_busy  in  1  bus controller still draining the queue
- o_program_address  out  5  queue write pointer (next free slot)
- i_program_address  in  5  bus controller read pointer
- o_program_data  out  5  queue entry at i_program_address: bit4 = command, [3:0] = nibble
- o_no_read  out  1  1 = do not clock a read nibble
- i_nibble  in  4  nibble read from the bus
- o_error  out  1  sticky decode error
- o_current_pc  out  20  address of the first nibble of the current instruction
- o_alu_reg_dest  out  5  destination register id
- o_alu_reg_src_1  out  5  source register id 1
- o_alu_reg_src_2  out  5  source register id 2
- o_alu_imm_value  out  4  immediate value
- o_alu_opcode  out  5  ALU opcode
- o_instr_type  out  4  instruction class
- o_instr_decoded  out  1  one-cycle pulse: decode complete

Behaviour:
- Reset (i_reset low, asynchronous) sets:
  - queue write pointer to 7; queue contents to {1,4}, {0,0} ×5, {1,0}
  - PC = 0; decoder idle; o_no_read = 1; o_error = 0
  - all ALU and type outputs = 0; o_instr_decoded = 0
- Queue:
  - o_program_data is combinational from i_program_address.
  - The queue is empty when i_program_address == o_program_address.
- Freeze: while i_debug_cycle = 1, no register changes except o_instr_decoded, which is forced to 0.
- Fetch enable: o_no_read = i_bus_busy | o_error | !(queue empty).
- Read (phases 0010, with o_no_read = 0):
  - capture i_nibble; PC <= PC + 1, wrapping at 20 bits.
  - On the first nibble of an instruction, latch o_current_pc = PC before the increment.
- Decode (phases 0100), 2-nibble instructions:
  - 2n: P=n → type 1, dest REG_P, imm n, opcode OP_COPY
  - 00–03: RTNSXM, RTN, RTNSC, RTNCC → type 2, imm = second nibble
  - 04/05: SETHEX/SETDEC → type 3, imm = second nibble
  - 06: RSTK=C → type 1, dest REG_RSTK, src1 REG_C, opcode OP_COPY
  - 07: C=RSTK → type 1, dest REG_C, src1 REG_RSTK, opcode OP_COPY
  - 08–0F or any other first nibble → o_error = 1; decoding and reading stop until reset.
- On a complete decode: set the fields, pulse o_instr_decoded for exactly one clock in the 0100 cycle, then return to idle.
- Unused fields are 0; unused register ids are 5'h1F.
- Phase 1000: no action in this block.
- Reset mid-decode discards partial nibbles and re-queues the boot program.
- Simulation prints a message on each decode and on error.

Decomposition:
- Package saturn_pkg holds:
  - bus command codes: BUSCMD_PC_READ = 0, BUSCMD_LOAD_PC = 4
  - register ids: REG_C = 2, REG_P = 12, REG_RSTK = 14, REG_NONE = 31
  - ALU opcodes: OP_COPY = 1
  - instruction types: NONE = 0, ALU = 1, RTN = 2, MODE = 3
- One sub-module, saturn_inst_decoder: nibble-serial decoder. The top level keeps the queue, PC, and the fetch gating.

Test Plan:
- Reset, then drain the queue one entry per 0001 phase → entries 14, 00, 00, 00, 00, 00, 10 in that order; o_no_read = 1 until pointers match and i_bus_busy = 0.
- Feed nibbles 2, 5 → o_instr_decoded pulse; type 1, dest 12, imm 5, opcode 1; o_current_pc = 0; next instruction's o_current_pc = 2.
- Feed 0, 3 → type 2, imm 3. Feed 0, 7 → dest 2, src1 14.
- Feed 1 → o_error = 1 at the 0100 phase; o_no_read stays 1; further nibbles are ignored.
- Assert i_debug_cycle across a 0010 phase with nibble 2 → PC and decoder state unchanged; the read occurs on the next non-debug cycle.
- Pull i_reset low after the first nibble → PC = 0, o_error = 0, o_program_address = 7, o_instr_decoded = 0 immediately.
